// File: rtl/io_bridge.sv
// io_bridge: memory-bus decoder between the CPU external bus and the
// 128 KB RAM / memory-mapped I/O space (cpu_a[17:16] == 2'b11).
//
// I/O map (byte addresses, low 18 bits):
//   0x30000  write: push byte to TX FIFO (0x00 ignored)
//            read : pop RX FIFO head (0x00 when empty)
//   0x30004  write: set program_finish
//            read : snapshot cycle counter, return byte 0
//   0x30005-7 read: snapshot bytes 1..3
//   others   writes ignored, reads return 0x00
//
// Ports:
//   clk_in, rst_n_in            clock, async active-low reset
//   rdy_in                      CPU ready; bus ignored while low
//   cpu_a/cpu_wr/cpu_dout       CPU bus request
//   cpu_din                     read data, valid the cycle after the read
//   io_buffer_full              TX FIFO near full
//   ram_a/ram_we/ram_wdata      RAM port (ram_rdata has 1-cycle latency)
//   tx_data/tx_valid/tx_ready   UART TX handshake
//   rx_data/rx_valid            UART RX strobe
//   program_finish              sticky finish flag
//   tx_overflow/rx_overflow     sticky FIFO drop flags
module io_bridge #(
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_finish,
    output logic        tx_overflow,
    output logic        rx_overflow
);

    localparam int TX_AW    = $clog2(TX_DEPTH);
    localparam int RX_AW    = $clog2(RX_DEPTH);
    localparam int FULL_LVL = TX_DEPTH - FULL_MARGIN;

    // Upper address bits play no part in decode.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cpu_a[31:18];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic io_sel, io_wr, io_rd, acc_rd;
    logic a_fifo, a_fin, a_cnt1, a_cnt2, a_cnt3;

    assign io_sel = (cpu_a[17:16] == 2'b11);
    assign io_wr  = rdy_in & cpu_wr & io_sel;
    assign io_rd  = rdy_in & ~cpu_wr & io_sel;
    assign acc_rd = rdy_in & ~cpu_wr;

    assign a_fifo = (cpu_a[17:0] == 18'h30000);
    assign a_fin  = (cpu_a[17:0] == 18'h30004);
    assign a_cnt1 = (cpu_a[17:0] == 18'h30005);
    assign a_cnt2 = (cpu_a[17:0] == 18'h30006);
    assign a_cnt3 = (cpu_a[17:0] == 18'h30007);

    assign ram_a     = cpu_a[16:0];
    assign ram_wdata = cpu_dout;
    assign ram_we    = rdy_in & cpu_wr & ~io_sel;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]   tx_count;
    logic             tx_full, tx_pop, tx_push_req, tx_push;

    assign tx_full     = (tx_count == TX_DEPTH[TX_AW:0]);
    assign tx_valid    = (tx_count != '0);
    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push_req = io_wr & a_fifo & (cpu_dout != 8'h00);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    // Gated so the UART never sees stale storage while idle or after reset.
    assign tx_data     = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;

    assign io_buffer_full = (tx_count >= FULL_LVL[TX_AW:0]);

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= cpu_dout;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_wr_ptr   <= '0;
            tx_rd_ptr   <= '0;
            tx_count    <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
            if (tx_push_req & ~tx_push) tx_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_count;
    logic             rx_full, rx_empty, rx_pop, rx_push;
    logic [7:0]       rx_head;

    assign rx_full  = (rx_count == RX_DEPTH[RX_AW:0]);
    assign rx_empty = (rx_count == '0);
    assign rx_pop   = io_rd & a_fifo & ~rx_empty;
    assign rx_push  = rx_valid & (~rx_full | rx_pop);
    assign rx_head  = rx_mem[rx_rd_ptr];

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_count    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
            if (rx_valid & ~rx_push) rx_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter, I/O read register, read-return select, finish flag
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt, snapshot;
    logic [7:0]  io_q;
    logic        last_sel_io;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cycle_cnt      <= '0;
            snapshot       <= '0;
            io_q           <= '0;
            last_sel_io    <= 1'b0;
            program_finish <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (acc_rd) last_sel_io <= io_sel;
            if (io_wr & a_fin) program_finish <= 1'b1;
            if (io_rd) begin
                if (a_fifo) begin
                    io_q <= rx_empty ? 8'h00 : rx_head;
                end else if (a_fin) begin
                    // Byte 0 re-captures so bytes 1..3 belong to the same value.
                    snapshot <= cycle_cnt;
                    io_q     <= cycle_cnt[7:0];
                end else if (a_cnt1) begin
                    io_q <= snapshot[15:8];
                end else if (a_cnt2) begin
                    io_q <= snapshot[23:16];
                end else if (a_cnt3) begin
                    io_q <= snapshot[31:24];
                end else begin
                    io_q <= 8'h00;
                end
            end
        end
    end

    assign cpu_din = last_sel_io ? io_q : ram_rdata;

endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        program_finish;
    logic        tx_overflow;
    logic        rx_overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] cyc;

    io_bridge #(.TX_DEPTH(16), .RX_DEPTH(16), .FULL_MARGIN(2)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .program_finish(program_finish),
        .tx_overflow(tx_overflow), .rx_overflow(rx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Bytes accepted by the UART side.
    always @(posedge clk_in) begin
        if (rst_n_in && tx_valid && tx_ready) tx_q.push_back(tx_data);
    end

    // Reference cycle count: zero out of reset, +1 every clock.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cyc <= '0;
        else           cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b0; cpu_wr = 1'b0; cpu_a = '0; cpu_dout = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        rdy_in = 1'b1; cpu_wr = 1'b1; cpu_a = a; cpu_dout = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [31:0] a);
        rdy_in = 1'b1; cpu_wr = 1'b0; cpu_a = a;
        tick();
    endtask

    task automatic rx_byte(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; rx_data = '0;
    endtask

    initial begin
        rst_n_in = 1'b0;
        idle();
        ram_rdata = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        #12;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_full", io_buffer_full, 0);
        chk("rst_finish", program_finish, 0);
        chk("rst_tx_ovf", tx_overflow, 0);
        chk("rst_rx_ovf", rx_overflow, 0);
        chk("rst_cpu_din", cpu_din, 0);
        chk("rst_ram_we", ram_we, 0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;

        // 0x00 is filtered out of the TX stream.
        tx_ready = 1'b1;
        wr(32'h30000, 8'h41);
        chk("tx_first_valid", tx_valid, 1);
        chk("tx_first_data", tx_data, 8'h41);
        wr(32'h30000, 8'h00);
        wr(32'h30000, 8'h42);
        tick(); tick();
        chk("tx_stream_len", tx_q.size(), 2);
        if (tx_q.size() == 2) begin
            chk("tx_stream_0", tx_q[0], 8'h41);
            chk("tx_stream_1", tx_q[1], 8'h42);
        end
        tx_q.delete();

        // Fill, near-full flag, overflow, ordered drain.
        tx_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            wr(32'h30000, 8'(i));
            if (i == 13) chk("full_at_13", io_buffer_full, 0);
        end
        chk("full_at_14", io_buffer_full, 1);
        wr(32'h30000, 8'h0F);
        wr(32'h30000, 8'h10);
        chk("tx_ovf_at_16", tx_overflow, 0);
        chk("tx_hold_data", tx_data, 8'h01);
        wr(32'h30000, 8'h11);
        chk("tx_ovf_at_17", tx_overflow, 1);
        tx_ready = 1'b1;
        for (int n = 0; n < 40 && tx_valid; n++) tick();
        chk("tx_drain_done", tx_valid, 0);
        chk("full_after_drain", io_buffer_full, 0);
        chk("drain_len", tx_q.size(), 16);
        for (int i = 0; i < 16 && i < tx_q.size(); i++)
            chk($sformatf("drain_%0d", i), tx_q[i], 32'(i + 1));
        tx_q.delete();

        // RX FIFO reads, including the empty case.
        rx_byte(8'h55);
        rx_byte(8'hAA);
        rd(32'h30000); chk("rx_read_0", cpu_din, 8'h55);
        rd(32'h30000); chk("rx_read_1", cpu_din, 8'hAA);
        rd(32'h30000); chk("rx_read_empty", cpu_din, 8'h00);
        idle();

        // Coherent 4-byte counter read across the 0x1FF -> 0x200 carry.
        for (int n = 0; n < 600 && cyc < 32'h1FF; n++) tick();
        chk("cnt_align", cyc, 32'h1FF);
        rd(32'h30004); chk("cnt_b0", cpu_din, 8'hFF);
        rd(32'h30005); chk("cnt_b1", cpu_din, 8'h01);
        rd(32'h30006); chk("cnt_b2", cpu_din, 8'h00);
        rd(32'h30007); chk("cnt_b3", cpu_din, 8'h00);
        begin
            logic [7:0] exp_b0;
            exp_b0 = cyc[7:0];
            rd(32'h30004); chk("cnt_b0_again", cpu_din, exp_b0);
        end
        rd(32'h3000C); chk("io_unmapped_read", cpu_din, 8'h00);
        idle();

        // RAM read then IO read back to back.
        rx_byte(8'h77);
        rd(32'h00010);
        chk("ram_a_pass", ram_a, 17'h00010);
        ram_rdata = 8'h3C;
        cpu_a = 32'h30000;
        #1;
        chk("ram_read_data", cpu_din, 8'h3C);
        chk("ram_we_io_read", ram_we, 0);
        tick();
        ram_rdata = 8'h00;
        #1;
        chk("io_after_ram", cpu_din, 8'h77);
        idle();

        rdy_in = 1'b1; cpu_wr = 1'b1; cpu_a = 32'h00020; cpu_dout = 8'h5A;
        #1;
        chk("ram_we_write", ram_we, 1);
        chk("ram_wdata_pass", ram_wdata, 8'h5A);
        cpu_a = 32'h30008;
        #1;
        chk("ram_we_io_write", ram_we, 0);
        tick();
        idle();

        // RX overflow after 16 entries.
        for (int i = 0; i < 16; i++) rx_byte(8'(8'h80 + i));
        chk("rx_ovf_at_16", rx_overflow, 0);
        rx_byte(8'hEE);
        chk("rx_ovf_at_17", rx_overflow, 1);
        rd(32'h30000); chk("rx_full_head", cpu_din, 8'h80);
        idle();

        // rdy_in low blocks the push.
        rdy_in = 1'b0; cpu_wr = 1'b1; cpu_a = 32'h30000; cpu_dout = 8'h99;
        tick();
        idle();
        chk("no_push_rdy_low", tx_valid, 0);
        wr(32'h30004, 8'h01);
        chk("finish_set", program_finish, 1);

        // Reset in the middle of a drain.
        tx_ready = 1'b0;
        wr(32'h30000, 8'h21);
        wr(32'h30000, 8'h22);
        wr(32'h30000, 8'h23);
        tx_ready = 1'b1;
        tick();
        chk("mid_drain_valid", tx_valid, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("rst_async_tx_valid", tx_valid, 0);
        chk("rst_async_finish", program_finish, 0);
        chk("rst_async_tx_ovf", tx_overflow, 0);
        chk("rst_async_rx_ovf", rx_overflow, 0);
        #10;
        rst_n_in = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Sits directly downstream of the CPU's external memory bus: decodes each byte access and routes it to the 128 KB RAM port or to the memory-mapped I/O space (mem_a[17:16]==2'b11).
- Owns a TX byte FIFO that drains to the UART transmitter and generates the CPU's io_buffer_full.
- Owns an RX byte FIFO filled by the UART receiver, a free-running cycle counter and the program-finish flag.
- Returns read data one cycle after the access, which is the latency the CPU's memory controller relies on.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of two, minimum 4.
- RX_DEPTH, 16, RX FIFO entries; power of two, minimum 2.
- FULL_MARGIN, 2, io_buffer_full asserts when tx_count >= TX_DEPTH-FULL_MARGIN. Covers writes already in flight.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  CPU ready; bus accesses are ignored while low
- cpu_a  in  32  byte address from CPU (mem_a)
- cpu_wr  in  1  1 = write, 0 = read (mem_wr)
- cpu_dout  in  8  write data from CPU (mem_dout)
- cpu_din  out  8  read data to CPU (mem_din), valid the cycle after the read
- io_buffer_full  out  1  TX FIFO near full
- ram_a  out  17  RAM byte address (cpu_a[16:0])
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, 1-cycle latency
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts the byte this cycle
- rx_data  in  8  byte from UART RX
- rx_valid  in  1  one-cycle strobe: rx_data is a new byte
- program_finish  out  1  sticky, set by a write to 0x30004
- tx_overflow  out  1  sticky, a TX push was dropped
- rx_overflow  out  1  sticky, an RX byte was dropped

Behaviour:
- Reset (async, rst_n_in low): both FIFOs empty, cycle_cnt=0, snapshot=0, last_sel=RAM. All outputs 0 except the pass-through RAM address/data.
- Decode: io = (cpu_a[17:16]==2'b11), qualified by rdy_in. ram_a and ram_wdata are pass-through. ram_we = rdy_in & cpu_wr & ~io.
- IO write 0x30000: push cpu_dout into the TX FIFO, except that data 0x00 is ignored. If the FIFO is full, drop the byte and set tx_overflow.
- IO write 0x30004: set program_finish. It stays set until reset.
- Other IO addresses: writes are ignored; reads return 0x00.
- IO read 0x30000: pop the RX FIFO head into io_q. If the RX FIFO is empty, io_q=0x00 and nothing pops.
- IO read 0x30004: snapshot <= cycle_cnt; io_q <= cycle_cnt[7:0].
- IO read 0x30005/6/7: io_q <= snapshot byte 1/2/3. Byte 0 always reloads the snapshot, so a 4-byte read yields a coherent value.
- Read-return mux:
  - On every read, last_sel is registered as RAM or IO.
  - cpu_din = (last_sel==IO) ? io_q : ram_rdata.
  - On a write or idle cycle, last_sel holds its previous value.
- cycle_cnt:
  - 32-bit, increments every clk_in, independent of rdy_in.
  - Wraps from 0xFFFFFFFF to 0.
  - The byte-0 read sees the pre-increment value of that cycle.
- TX FIFO:
  - Circular buffer with a count of width log2(TX_DEPTH)+1.
  - tx_valid = (count != 0); tx_data = head entry, stable while tx_valid & ~tx_ready.
  - A pop occurs on tx_valid & tx_ready.
  - Simultaneous push and pop leaves count unchanged, and is legal even when full.
  - Pointers wrap modulo depth.
- io_buffer_full = (tx_count >= TX_DEPTH-FULL_MARGIN). It is combinational from the registered count, so it is glitch-free within a cycle.
- RX FIFO:
  - rx_valid pushes rx_data.
  - When full and not popped in the same cycle, drop the byte and set rx_overflow.
  - A simultaneous push and pop is allowed.
- rdy_in low: no push, no pop, no snapshot, no program_finish update, ram_we=0, last_sel and io_q hold. TX drain and RX fill continue.
- Reset asserted mid-transfer: all state clears immediately. tx_valid falls asynchronously and any partially accepted byte is lost.

Test Plan:
- Reset, then write 0x41,0x00,0x42 to 0x30000 with tx_ready=1 -> tx_valid carries exactly 0x41 then 0x42; the 0x00 is never presented.
- tx_ready=0, 14 writes to 0x30000 with TX_DEPTH=16 -> io_buffer_full=1 after the 14th push. A 17th write drops and sets tx_overflow. Raising tx_ready drains 16 bytes in order.
- Counter read:
  - Hold cycle_cnt near 0x000001FF.
  - Read 0x30004..0x30007 on consecutive cycles -> cpu_din returns the snapshot bytes the cycle after each read.
  - The 4 bytes form a single value; bytes 1..3 do not reflect later increments.
- rx_valid with 0x55 and 0xAA, then three reads of 0x30000 -> cpu_din = 0x55, 0xAA, 0x00 on the respective next cycles.
- Interleave a RAM read at 0x00010 (ram_rdata=0x3C) and an IO read at 0x30000 -> cpu_din = 0x3C then the RX byte, each one cycle later. ram_we stays 0 for the IO read.
- Drop rdy_in during an IO write to 0x30000 -> no push. Write to 0x30004 -> program_finish=1. Assert rst_n_in mid-drain -> tx_valid=0 and program_finish=0 at once.
